lsu_dccm_port_arb: RTL and testbench

LSU_DCCM_PORT_ARB -- requirements
Module: lsu_dccm_port_arb

---
 rtl/lsu_dccm_port_arb_if.sv | 45 ++++
 rtl/lsu_dccm_port_arb.sv | 154 +++++++++++++++
 tb/tb_lsu_dccm_port_arb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dccm_port_arb_if.sv
// Core/DMA request bundle and the single downstream DCCM beat port shared by lsu_dccm_port_arb.
// The slave modport is the arbiter side; the master modport is the requesters/downstream side.
interface lsu_dccm_port_arb_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SIZE_W = 2;

  logic              lsu_req;
  logic [ADDR_W-1:0] lsu_addr;
  logic [SIZE_W-1:0] lsu_size;
  logic              lsu_write;
  logic              lsu_gnt;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [SIZE_W-1:0] dma_size;
  logic              dma_write;
  logic              dma_gnt;

  logic              port_ready;
  logic              port_valid;
  logic              port_dma;
  logic              port_write;
  logic [SIZE_W-1:0] port_size;
  logic [ADDR_W-1:0] port_start_addr;
  logic [ADDR_W-1:0] port_end_addr;
  logic              dma_beat;

  modport master (
    output lsu_req, lsu_addr, lsu_size, lsu_write,
    output dma_req, dma_addr, dma_size, dma_write,
    output port_ready,
    input  lsu_gnt, dma_gnt,
    input  port_valid, port_dma, port_write, port_size,
    input  port_start_addr, port_end_addr, dma_beat
  );

  modport slave (
    input  lsu_req, lsu_addr, lsu_size, lsu_write,
    input  dma_req, dma_addr, dma_size, dma_write,
    input  port_ready,
    output lsu_gnt, dma_gnt,
    output port_valid, port_dma, port_write, port_size,
    output port_start_addr, port_end_addr, dma_beat
  );
endinterface

// File: rtl/lsu_dccm_port_arb.sv
// Arbitrates core LSU and DMA onto one DCCM beat port; DMA dwords are split into two word beats.
// Define RV_DMA_STARVE_PROT_EN to add the DMA wait counter that forces DMA ahead of a busy core.
module lsu_dccm_port_arb #(
  parameter int unsigned DMA_MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  lsu_dccm_port_arb_if.slave     bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned WAIT_W = 3;

  if (DMA_MAX_WAIT < 1 || DMA_MAX_WAIT > 7) begin : g_param_check
    $error("DMA_MAX_WAIT must be within 1..7");
  end

  typedef enum logic {IDLE, DMA_B2} state_t;

  state_t state, state_nxt;
  // Winner of a stalled IDLE beat, kept so a later arrival cannot pre-empt it.
  logic   locked, locked_nxt;
  logic   locked_dma, locked_dma_nxt;
`ifdef RV_DMA_STARVE_PROT_EN
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
`endif

  logic              in_b2;
  logic              starve;
  logic              sel_dma;
  logic              fire;
  logic [SIZE_W-1:0] lsu_sz;
  logic [SIZE_W-1:0] dma_sz;
  logic [1:0]        bytes_m1;
  logic              valid;
  logic              is_dma;
  logic              wr;
  logic [SIZE_W-1:0] sz;
  logic [ADDR_W-1:0] start_addr;
  logic              beat;
  logic              lsu_gnt;
  logic              dma_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      locked     <= 1'b0;
      locked_dma <= 1'b0;
`ifdef RV_DMA_STARVE_PROT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      locked     <= locked_nxt;
      locked_dma <= locked_dma_nxt;
`ifdef RV_DMA_STARVE_PROT_EN
      wait_cnt   <= wait_cnt_nxt;
`endif
    end
  end

  // Reset forces an IDLE view on the outputs so an abandoned second beat is never granted.
  always_comb begin
    state_nxt      = state;
    locked_nxt     = 1'b0;
    locked_dma_nxt = locked_dma;
    valid          = 1'b0;
    is_dma         = 1'b0;
    wr             = 1'b0;
    sz             = '0;
    start_addr     = '0;
    beat           = 1'b0;
    lsu_gnt        = 1'b0;
    dma_gnt        = 1'b0;
    sel_dma        = 1'b0;
    bytes_m1       = 2'd0;

    in_b2  = (state == DMA_B2) && !rst;
    lsu_sz = (bus.lsu_size == 2'd3) ? 2'd2 : bus.lsu_size;
    dma_sz = (bus.dma_size == 2'd3) ? 2'd2 : bus.dma_size;
`ifdef RV_DMA_STARVE_PROT_EN
    starve = !rst && (wait_cnt == WAIT_W'(DMA_MAX_WAIT));
`else
    starve = 1'b0;
`endif

    if (locked && !rst)                 sel_dma = locked_dma;
    else if (bus.lsu_req && bus.dma_req) sel_dma = starve;
    else                                 sel_dma = bus.dma_req;

    if (in_b2) begin
      valid      = 1'b1;
      is_dma     = 1'b1;
      wr         = bus.dma_write;
      sz         = 2'd2;
      start_addr = bus.dma_addr + ADDR_W'(4);
      beat       = 1'b1;
    end else if (sel_dma) begin
      valid      = 1'b1;
      is_dma     = 1'b1;
      wr         = bus.dma_write;
      sz         = dma_sz;
      start_addr = bus.dma_addr;
    end else if (bus.lsu_req) begin
      valid      = 1'b1;
      wr         = bus.lsu_write;
      sz         = lsu_sz;
      start_addr = bus.lsu_addr;
    end

    case (sz)
      2'd0:    bytes_m1 = 2'd0;
      2'd1:    bytes_m1 = 2'd1;
      default: bytes_m1 = 2'd3;
    endcase

    fire = valid && bus.port_ready;

    if (!rst) begin
      if (in_b2)        dma_gnt = fire;
      else if (sel_dma) dma_gnt = fire && (bus.dma_size != 2'd3);
      else              lsu_gnt = fire;
    end

    if (in_b2) begin
      if (bus.port_ready) state_nxt = IDLE;
    end else if (fire && sel_dma && (bus.dma_size == 2'd3)) begin
      state_nxt = DMA_B2;
    end

    if (!in_b2 && valid && !bus.port_ready) begin
      locked_nxt     = 1'b1;
      locked_dma_nxt = sel_dma;
    end

`ifdef RV_DMA_STARVE_PROT_EN
    wait_cnt_nxt = wait_cnt;
    if (!bus.dma_req || (fire && is_dma))
      wait_cnt_nxt = '0;
    else if (state == IDLE && wait_cnt < WAIT_W'(DMA_MAX_WAIT))
      wait_cnt_nxt = wait_cnt + WAIT_W'(1);
`endif
  end

  assign bus.port_valid      = valid;
  assign bus.port_dma        = is_dma;
  assign bus.port_write      = wr;
  assign bus.port_size       = sz;
  assign bus.port_start_addr = start_addr;
  assign bus.port_end_addr   = valid ? (start_addr + ADDR_W'(bytes_m1)) : '0;
  assign bus.dma_beat        = beat;
  assign bus.lsu_gnt         = lsu_gnt;
  assign bus.dma_gnt         = dma_gnt;
endmodule

// File: tb/tb_lsu_dccm_port_arb.sv
// Bench for lsu_dccm_port_arb: directed vector table, hand-written corner sequences and
// constrained-random traffic against a transaction-level reference model.
module tb_lsu_dccm_port_arb;
  localparam int unsigned DMA_MAX_WAIT = 4;
`ifdef RV_DMA_STARVE_PROT_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_dccm_port_arb_if bus();

  lsu_dccm_port_arb #(.DMA_MAX_WAIT(DMA_MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: pending DMA second beat, owner of a stalled beat (0 none, 1 core, 2 dma), DMA losses.
  bit m_b2;
  int m_owner;
  int m_wait;
  int cur_win;

  logic        e_valid, e_dma, e_write, e_beat, e_lg, e_dg;
  logic [1:0]  e_size;
  logic [31:0] e_start, e_end;
  logic        a_valid, a_dma, a_lg, a_dg, a_beat;
  logic [31:0] a_start;

  typedef struct {
    logic        rst, lr;
    logic [31:0] la;
    logic [1:0]  ls;
    logic        lw, dr;
    logic [31:0] da;
    logic [1:0]  ds;
    logic        dw, rdy;
    logic [71:0] exp;
  } vec_t;

  function automatic logic [71:0] ex(logic v, logic d, logic w, logic [1:0] s, logic [31:0] st,
                                     logic [31:0] en, logic b, logic lg, logic dg);
    return {v, d, w, s, st, en, b, lg, dg};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_expect();
    bit b2;
    int owner, w, sz;
    b2 = rst ? 1'b0 : m_b2;
    owner = rst ? 0 : m_owner;
    w = rst ? 0 : m_wait;
    {e_valid, e_dma, e_write, e_beat, e_lg, e_dg} = '0;
    e_start = '0; e_end = '0; sz = 0; cur_win = 0;
    if (b2) begin
      cur_win = 2; e_valid = 1; e_dma = 1; e_write = bus.dma_write; sz = 2;
      e_start = bus.dma_addr + 32'd4; e_beat = 1;
    end else begin
      if (owner != 0) cur_win = owner;
      else if (bus.lsu_req && bus.dma_req) cur_win = (STARVE && w == DMA_MAX_WAIT) ? 2 : 1;
      else if (bus.lsu_req) cur_win = 1;
      else if (bus.dma_req) cur_win = 2;
      if (cur_win == 1) begin
        e_valid = 1; e_write = bus.lsu_write; e_start = bus.lsu_addr;
        sz = (int'(bus.lsu_size) > 2) ? 2 : int'(bus.lsu_size);
      end else if (cur_win == 2) begin
        e_valid = 1; e_dma = 1; e_write = bus.dma_write; e_start = bus.dma_addr;
        sz = (int'(bus.dma_size) > 2) ? 2 : int'(bus.dma_size);
      end
    end
    e_size = 2'(sz);
    if (e_valid) e_end = e_start + 32'((1 << sz) - 1);
    if (!rst && e_valid && bus.port_ready) begin
      if (b2) e_dg = 1;
      else if (cur_win == 1) e_lg = 1;
      else if (bus.dma_size != 2'd3) e_dg = 1;
    end
  endtask

  task automatic model_update();
    bit xfer, old_b2;
    if (rst) begin
      m_b2 = 0; m_owner = 0; m_wait = 0;
      return;
    end
    xfer = e_valid && bus.port_ready;
    old_b2 = m_b2;
    if (m_b2) begin
      if (bus.port_ready) m_b2 = 0;
    end else if (xfer) begin
      m_owner = 0;
      if (e_dma && bus.dma_size == 2'd3) m_b2 = 1;
    end else begin
      m_owner = e_valid ? cur_win : 0;
    end
    if (!bus.dma_req || (xfer && e_dma)) m_wait = 0;
    else if (!old_b2 && m_wait < int'(DMA_MAX_WAIT)) m_wait++;
  endtask

  // One cycle: inputs already driven after a falling edge; check, then clock the model.
  task automatic tick(input bit use_tbl, input logic [71:0] texp, input string nm);
    logic [71:0] act, mexp;
    #1;
    model_expect();
    act = {bus.port_valid, bus.port_dma, bus.port_write, bus.port_size, bus.port_start_addr,
           bus.port_end_addr, bus.dma_beat, bus.lsu_gnt, bus.dma_gnt};
    mexp = {e_valid, e_dma, e_write, e_size, e_start, e_end, e_beat, e_lg, e_dg};
    a_valid = bus.port_valid; a_dma = bus.port_dma; a_lg = bus.lsu_gnt;
    a_dg = bus.dma_gnt; a_beat = bus.dma_beat; a_start = bus.port_start_addr;
    n_chk++;
    if (act !== mexp) begin
      n_fail++;
      $display("FAIL model %s: got %h expected %h at %0t", nm, act, mexp, $time);
    end
    n_chk++;
    if (bus.lsu_gnt && bus.dma_gnt) begin
      n_fail++;
      $display("FAIL gnt_exclusive %s: got both grants at %0t", nm, $time);
    end
    if (use_tbl) begin
      n_chk++;
      if (act !== texp) begin
        n_fail++;
        $display("FAIL table %s: got %h expected %h", nm, act, texp);
      end
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_lsu(input logic r, input logic [31:0] a, input logic [1:0] s, input logic w);
    bus.lsu_req = r; bus.lsu_addr = a; bus.lsu_size = s; bus.lsu_write = w;
  endtask

  task automatic set_dma(input logic r, input logic [31:0] a, input logic [1:0] s, input logic w);
    bus.dma_req = r; bus.dma_addr = a; bus.dma_size = s; bus.dma_write = w;
  endtask

  task automatic do_reset();
    rst = 1; set_lsu(0, 0, 0, 0); set_dma(0, 0, 0, 0); bus.port_ready = 1;
    tick(0, '0, "reset");
    rst = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom % 4 == 0) ? 32'hFFFF_FFF8 + 32'($urandom % 8) : 32'($urandom);
  endfunction

  vec_t tbl[8];
  int   first_dma;

  initial begin
    m_b2 = 0; m_owner = 0; m_wait = 0;
    rst = 1; set_lsu(0, 0, 0, 0); set_dma(0, 0, 0, 0); bus.port_ready = 0;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{0, 1, 32'h0000_1000, 2, 0, 0, 0, 0, 0, 1,
               ex(1, 0, 0, 2, 32'h0000_1000, 32'h0000_1003, 0, 1, 0)};
    tbl[2] = '{0, 1, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 0, 1,
               ex(1, 0, 1, 1, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 0)};
    tbl[3] = '{0, 1, 32'h0000_0010, 3, 0, 0, 0, 0, 0, 1,
               ex(1, 0, 0, 2, 32'h0000_0010, 32'h0000_0013, 0, 1, 0)};
    tbl[4] = '{0, 0, 0, 0, 0, 1, 32'h0000_2000, 3, 1, 1,
               ex(1, 1, 1, 2, 32'h0000_2000, 32'h0000_2003, 0, 0, 0)};
    tbl[5] = '{0, 0, 0, 0, 0, 1, 32'h0000_2000, 3, 1, 1,
               ex(1, 1, 1, 2, 32'h0000_2004, 32'h0000_2007, 1, 0, 1)};
    tbl[6] = '{0, 0, 0, 0, 0, 1, 32'h0000_3001, 0, 0, 1,
               ex(1, 1, 0, 0, 32'h0000_3001, 32'h0000_3001, 0, 0, 1)};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0)};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst;
      set_lsu(tbl[i].lr, tbl[i].la, tbl[i].ls, tbl[i].lw);
      set_dma(tbl[i].dr, tbl[i].da, tbl[i].ds, tbl[i].dw);
      bus.port_ready = tbl[i].rdy;
      tick(1, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Core and DMA both held: starvation protection decides when DMA gets in.
    do_reset();
    set_lsu(1, 32'h0000_0100, 2, 0); set_dma(1, 32'h0000_0400, 2, 1);
    first_dma = -1;
    for (int i = 0; i < 12; i++) begin
      tick(0, '0, "starve");
      if (a_valid && a_dma && first_dma < 0) first_dma = i;
      if (a_dg) bus.dma_req = 0;
    end
    chk("starve_first_dma_cycle", 32'(first_dma), STARVE ? 32'd4 : 32'hFFFF_FFFF);

    // Second DMA beat stalled with core pending.
    do_reset();
    set_lsu(0, 0, 0, 0); set_dma(1, 32'h0000_5000, 3, 0);
    tick(0, '0, "b2_first");
    set_lsu(1, 32'h0000_0200, 2, 1); bus.port_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(0, '0, "b2_stall");
      chk("b2_stall_start", a_start, 32'h0000_5004);
      chk("b2_stall_lsu_gnt", 32'(a_lg), 32'd0);
    end
    bus.port_ready = 1;
    tick(0, '0, "b2_release");
    chk("b2_release_dma_gnt", 32'(a_dg), 32'd1);
    bus.dma_req = 0;
    tick(0, '0, "b2_core_after");
    chk("b2_core_after_gnt", 32'(a_lg), 32'd1);

    // Reset while in DMA_B2 abandons the second beat.
    do_reset();
    set_dma(1, 32'h0000_6000, 3, 1);
    tick(0, '0, "rst_b2_first");
    rst = 1;
    tick(0, '0, "rst_b2_in_reset");
    chk("rst_b2_no_gnt", 32'(a_dg), 32'd0);
    chk("rst_b2_beat", 32'(a_beat), 32'd0);
    rst = 0;
    tick(0, '0, "rst_b2_restart");
    chk("rst_b2_restart_start", a_start, 32'h0000_6000);
    chk("rst_b2_restart_no_gnt", 32'(a_dg), 32'd0);
    tick(0, '0, "rst_b2_second");
    chk("rst_b2_second_gnt", 32'(a_dg), 32'd1);
    bus.dma_req = 0;

    // A stalled DMA winner is not pre-empted by a later core request.
    do_reset();
    set_dma(1, 32'h0000_7000, 2, 0); bus.port_ready = 0;
    tick(0, '0, "lock_dma_stall");
    set_lsu(1, 32'h0000_0300, 2, 0);
    tick(0, '0, "lock_core_arrives");
    chk("lock_still_dma", 32'(a_dma), 32'd1);
    bus.port_ready = 1;
    tick(0, '0, "lock_release");
    chk("lock_release_dma_gnt", 32'(a_dg), 32'd1);
    bus.dma_req = 0;
    tick(0, '0, "lock_core_next");

    // Random traffic: requests held until granted, random stalls and occasional reset.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!bus.lsu_req || e_lg)
        set_lsu(1'($urandom % 3 != 0), rnd_addr(), 2'($urandom), 1'($urandom));
      if (!bus.dma_req || e_dg)
        set_dma(1'($urandom % 2), rnd_addr(), 2'($urandom), 1'($urandom));
      bus.port_ready = 1'($urandom % 4 != 0);
      rst = 1'($urandom % 60 == 0);
      tick(0, '0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
